recirc_return_mux: RTL and testbench
====================================

// Module: recirc_return_mux
// PURPOSE
// - Return end of the lane demux-with-recirculation path: accepts the 4 fresh lane streams and the 4 recirculated
//   streams (data_Xrp) and merges them back into 4 registered lane outputs.
// - Recirculated bytes are buffered per lane until the fresh stream on that lane is silent.
// - Also generates the idle indication (idle_out) that the demux stage uses to choose pass-through vs recirculation.
// PARAMETERS
// - DATA_W      8  lane byte width
// - FIFO_DEPTH  4  recirculation buffer entries per lane (power of 2, >=2)
// - IDLE_HOLD   4  consecutive all-lane-silent cycles before ACTIVE->IDLE
// PORTS
// - clk_f                   in   1       single clock; all state on rising edge
// - reset                   in   1       asynchronous, active-low reset
// - data_0p..data_3p        in   DATA_W  fresh lane bytes
// - valid_0p..valid_3p      in   1       fresh byte valid, per lane
// - data_0rp..data_3rp      in   DATA_W  recirculated lane bytes
// - valid_0rp..valid_3rp    in   1       recirculated byte valid, per lane
// - data_0..data_3          out  DATA_W  merged lane bytes (registered)
// - valid_0..valid_3        out  1       merged byte valid (registered)
// - idle_out                out  1       1 = link idle (FSM in IDLE)
// - ovf_0..ovf_3            out  1       sticky: recirculated byte dropped on full buffer
// BEHAVIOUR
// - Reset (reset=0, async): all data_X=0, valid_X=0, ovf_X=0, idle_out=1, FIFOs empty, FSM=IDLE, silence counter=0.
// - Per lane each cycle, with fresh valid (F), buffer non-empty (NE) and recirc valid (R):
//   * F=1: output <= data_Xp, valid <= 1; buffer not popped.
//   * F=0, NE=1: output <= buffer head, valid <= 1; pop.
//   * F=0, NE=0, R=1: bypass; output <= data_Xrp, valid <= 1; nothing stored.
//   * all 0: valid <= 0; data holds its last value.
// - Push: R=1 and not bypassed -> write data_Xrp to tail. Latency input->output is 1 cycle.
// - Full buffer + R=1: pushed if a pop happens in the same cycle, otherwise dropped and ovf_X <= 1 (sticky until reset).
// - Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. Empty: ptrs equal. Full: MSB differs, rest equal.
// - FSM (2 states):
//   * IDLE -> ACTIVE when any next-cycle valid_X=1; silence counter cleared.
//   * ACTIVE: counter increments on cycles with all next valid_X=0 and clears on any valid.
//   * ACTIVE -> IDLE when counter reaches IDLE_HOLD-1 on a silent cycle and all buffers are empty.
//     Counter saturates while buffers are non-empty.
// - idle_out is registered; it equals (state==IDLE) and updates in the same edge as the valid outputs.
// - Reset mid-operation: buffered bytes are discarded, no partial output; first post-reset cycle behaves as from empty.
// - Lanes are independent; simultaneous events on different lanes never interact, except through the FSM.
// STRUCTURE
// - Shared package/include: DATA_W default, FIFO_DEPTH default, IDLE_HOLD default, FSM state encodings
//   (ST_IDLE=1'b0, ST_ACTIVE=1'b1).
// - Sub-module recirc_fifo (sync FIFO: push, pop, din, dout, empty, full), instantiated once per lane.
//   Merge priority, overflow flags and FSM live in the top.
// - Must synthesise with the standard flow to a gate-level synth_recirc_return_mux for conductual/structural compare.
// TESTING
// - Reset: hold reset=0 for 2 cycles with inputs toggling -> all valid_X=0, data_X=0, idle_out=1, ovf_X=0.
// - Fresh priority:
//   * lane0: valid_0p=1 data_0p=8'hAA and valid_0rp=1 data_0rp=8'h11 for 1 cycle
//     -> next edge data_0=8'hAA valid_0=1; 8'h11 is buffered.
//   * next cycle, no inputs -> data_0=8'h11 valid_0=1.
// - Bypass: lane2 empty, only valid_2rp=1 data_2rp=8'h5C -> next edge data_2=8'h5C valid_2=1, buffer stays empty.
// - Overflow:
//   * lane1: valid_1p=1 for 6 cycles while valid_1rp=1 with 8'h01..8'h06 -> 8'h01..8'h04 stored, 8'h05 and 8'h06
//     dropped, ovf_1=1.
//   * drain -> 8'h01,02,03,04 in order.
// - Idle FSM: single valid_3p pulse -> idle_out falls with valid_3, rises IDLE_HOLD=4 silent cycles later.
//   With a buffer still non-empty, idle_out stays 0 until it drains.
// - Wrap/async reset: push/pop 10 bytes through lane0 (pointer wrap, order kept), then assert reset mid-stream
//   -> outputs clear immediately without a clock edge.

Source files
------------

// File: rtl/recirc_return_mux_pkg.sv
// ---------------------------------------------------------------------------
// recirc_return_mux_pkg : shared defaults and FSM encoding for the return mux
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package recirc_return_mux_pkg;

  localparam int DATA_W_DFLT     = 8;
  localparam int FIFO_DEPTH_DFLT = 4;
  localparam int IDLE_HOLD_DFLT  = 4;
  localparam int NUM_LANES       = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } link_state_e;

endpackage

`default_nettype wire

// File: rtl/recirc_return_mux_fifo.sv
// ---------------------------------------------------------------------------
// recirc_fifo : per-lane synchronous FIFO holding recirculated bytes
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module recirc_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en, rd_en;

  // A push into a full FIFO is legal only when the head leaves in the same cycle
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/recirc_return_mux.sv
// ---------------------------------------------------------------------------
// recirc_return_mux : merges fresh and recirculated lane bytes, drives idle_out
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module recirc_return_mux
  import recirc_return_mux_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DFLT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DFLT,
  parameter int IDLE_HOLD  = IDLE_HOLD_DFLT
) (
  input  logic              clk_f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_0p,  data_1p,  data_2p,  data_3p,
  input  logic              valid_0p, valid_1p, valid_2p, valid_3p,
  input  logic [DATA_W-1:0] data_0rp,  data_1rp,  data_2rp,  data_3rp,
  input  logic              valid_0rp, valid_1rp, valid_2rp, valid_3rp,
  output logic [DATA_W-1:0] data_0,  data_1,  data_2,  data_3,
  output logic              valid_0, valid_1, valid_2, valid_3,
  output logic              idle_out,
  output logic              ovf_0, ovf_1, ovf_2, ovf_3
);

  localparam int CW = $clog2(IDLE_HOLD) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(IDLE_HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [DATA_W-1:0]    fresh_data [NUM_LANES];
  logic [DATA_W-1:0]    rc_data    [NUM_LANES];
  logic [DATA_W-1:0]    head       [NUM_LANES];
  logic [DATA_W-1:0]    data_q     [NUM_LANES];
  logic [DATA_W-1:0]    data_d     [NUM_LANES];
  logic [NUM_LANES-1:0] fresh_v, rc_v, empty, full, push, pop;
  logic [NUM_LANES-1:0] valid_q, valid_d, ovf_q, ovf_d;
  link_state_e          state_q, state_d;
  logic [CW-1:0]        sil_cnt_q, sil_cnt_d;

  assign fresh_data = '{data_0p, data_1p, data_2p, data_3p};
  assign rc_data    = '{data_0rp, data_1rp, data_2rp, data_3rp};
  assign fresh_v    = {valid_3p, valid_2p, valid_1p, valid_0p};
  assign rc_v       = {valid_3rp, valid_2rp, valid_1rp, valid_0rp};

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      recirc_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
      ) u_fifo (
        .clk   (clk_f),
        .rst_n (reset),
        .push  (push[l]),
        .pop   (pop[l]),
        .din   (rc_data[l]),
        .dout  (head[l]),
        .empty (empty[l]),
        .full  (full[l])
      );
    end
  endgenerate

  // Priority per lane: fresh byte, then buffered head, then recirculated bypass
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      logic bypass, push_req;
      pop[l]     = !fresh_v[l] && !empty[l];
      bypass     = !fresh_v[l] && empty[l] && rc_v[l];
      push_req   = rc_v[l] && !bypass;
      push[l]    = push_req && (!full[l] || pop[l]);
      ovf_d[l]   = ovf_q[l] | (push_req && full[l] && !pop[l]);
      valid_d[l] = fresh_v[l] || !empty[l] || rc_v[l];
      if (fresh_v[l])      data_d[l] = fresh_data[l];
      else if (!empty[l])  data_d[l] = head[l];
      else if (rc_v[l])    data_d[l] = rc_data[l];
      else                 data_d[l] = data_q[l];
    end
  end

  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < NUM_LANES; l++) data_q[l] <= '0;
      valid_q   <= '0;
      ovf_q     <= '0;
      state_q   <= ST_IDLE;
      sil_cnt_q <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) data_q[l] <= data_d[l];
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      sil_cnt_q <= sil_cnt_d;
    end
  end

  // Silence is judged on the valids being registered this edge
  always_comb begin
    state_d   = state_q;
    sil_cnt_d = sil_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|valid_d) begin
          state_d   = ST_ACTIVE;
          sil_cnt_d = '0;
        end
      end
      ST_ACTIVE: begin
        if (|valid_d) begin
          sil_cnt_d = '0;
        end else if (sil_cnt_q == HOLD_LAST && &empty) begin
          state_d   = ST_IDLE;
          sil_cnt_d = '0;
        end else if (sil_cnt_q != HOLD_LAST) begin
          sil_cnt_d = sil_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        sil_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    idle_out = (state_q == ST_IDLE);
  end

  assign data_0  = data_q[0];
  assign data_1  = data_q[1];
  assign data_2  = data_q[2];
  assign data_3  = data_q[3];
  assign valid_0 = valid_q[0];
  assign valid_1 = valid_q[1];
  assign valid_2 = valid_q[2];
  assign valid_3 = valid_q[3];
  assign ovf_0   = ovf_q[0];
  assign ovf_1   = ovf_q[1];
  assign ovf_2   = ovf_q[2];
  assign ovf_3   = ovf_q[3];

endmodule

`default_nettype wire

// File: tb/tb_recirc_return_mux.sv
// ---------------------------------------------------------------------------
// tb_recirc_return_mux : queue-based reference model plus directed/random stimulus
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_recirc_return_mux;

  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int HOLD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] dp [4];
  logic [DW-1:0] drp [4];
  logic [3:0]    vp, vrp;
  logic [DW-1:0] d_o [4];
  logic [3:0]    v_o, ovf_o;
  logic          idle_o;

  int checks_total = 0;
  int checks_passed = 0;

  // reference model state
  logic [DW-1:0] mq [4][$];
  logic [DW-1:0] m_data [4];
  logic [3:0]    m_valid, m_ovf;
  logic          m_idle;
  int            m_run;

  always #5 clk = ~clk;

  recirc_return_mux dut (
    .clk_f(clk), .reset(rst_n),
    .data_0p(dp[0]), .data_1p(dp[1]), .data_2p(dp[2]), .data_3p(dp[3]),
    .valid_0p(vp[0]), .valid_1p(vp[1]), .valid_2p(vp[2]), .valid_3p(vp[3]),
    .data_0rp(drp[0]), .data_1rp(drp[1]), .data_2rp(drp[2]), .data_3rp(drp[3]),
    .valid_0rp(vrp[0]), .valid_1rp(vrp[1]), .valid_2rp(vrp[2]), .valid_3rp(vrp[3]),
    .data_0(d_o[0]), .data_1(d_o[1]), .data_2(d_o[2]), .data_3(d_o[3]),
    .valid_0(v_o[0]), .valid_1(v_o[1]), .valid_2(v_o[2]), .valid_3(v_o[3]),
    .idle_out(idle_o),
    .ovf_0(ovf_o[0]), .ovf_1(ovf_o[1]), .ovf_2(ovf_o[2]), .ovf_3(ovf_o[3])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int l = 0; l < 4; l++) begin
      mq[l].delete();
      m_data[l] = '0;
    end
    m_valid = '0;
    m_ovf   = '0;
    m_idle  = 1'b1;
    m_run   = 0;
  endtask

  task automatic model_update();
    bit all_empty;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int l = 0; l < 4; l++) begin
      m_valid[l] = 1'b1;
      if (vp[l]) begin
        m_data[l] = dp[l];
        if (vrp[l]) begin
          if (mq[l].size() < DEPTH) mq[l].push_back(drp[l]);
          else m_ovf[l] = 1'b1;
        end
      end else if (mq[l].size() > 0) begin
        m_data[l] = mq[l].pop_front();
        if (vrp[l]) mq[l].push_back(drp[l]);
      end else if (vrp[l]) begin
        m_data[l] = drp[l];
      end else begin
        m_valid[l] = 1'b0;
      end
    end
    all_empty = 1'b1;
    for (int l = 0; l < 4; l++) if (mq[l].size() != 0) all_empty = 1'b0;
    if (m_valid != 0) begin
      m_idle = 1'b0;
      m_run  = 0;
    end else if (!m_idle) begin
      m_run++;
      if (m_run >= HOLD && all_empty) begin
        m_idle = 1'b1;
        m_run  = 0;
      end
    end
  endtask

  task automatic compare();
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("valid_%0d", l), 32'(v_o[l]), 32'(m_valid[l]));
      chk($sformatf("data_%0d", l), 32'(d_o[l]), 32'(m_data[l]));
      chk($sformatf("ovf_%0d", l), 32'(ovf_o[l]), 32'(m_ovf[l]));
    end
    chk("idle_out", 32'(idle_o), 32'(m_idle));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  task automatic clear_in();
    vp = '0;
    vrp = '0;
    for (int l = 0; l < 4; l++) begin
      dp[l] = '0;
      drp[l] = '0;
    end
  endtask

  task automatic rand_in(input int pf, input int pr);
    for (int l = 0; l < 4; l++) begin
      vp[l]  = ($urandom_range(0, 99) < pf);
      vrp[l] = ($urandom_range(0, 99) < pr);
      dp[l]  = DW'($urandom);
      drp[l] = DW'($urandom);
    end
  endtask

  initial begin
    clear_in();
    model_reset();
    rst_n = 1'b0;

    // reset held with toggling inputs
    for (int i = 0; i < 2; i++) begin
      rand_in(50, 50);
      step();
    end
    chk("lit_rst_valid", 32'(v_o), 32'h0);
    chk("lit_rst_idle", 32'(idle_o), 32'h1);
    chk("lit_rst_ovf", 32'(ovf_o), 32'h0);
    chk("lit_rst_data0", 32'(d_o[0]), 32'h0);
    clear_in();
    rst_n = 1'b1;
    step();

    // fresh priority, recirculated byte buffered
    vp[0] = 1'b1; dp[0] = 8'hAA; vrp[0] = 1'b1; drp[0] = 8'h11;
    step();
    chk("lit_fresh_data", 32'(d_o[0]), 32'hAA);
    chk("lit_fresh_idle", 32'(idle_o), 32'h0);
    clear_in();
    step();
    chk("lit_buf_data", 32'(d_o[0]), 32'h11);
    chk("lit_buf_valid", 32'(v_o[0]), 32'h1);

    // bypass on empty lane
    vrp[2] = 1'b1; drp[2] = 8'h5C;
    step();
    chk("lit_bypass_data", 32'(d_o[2]), 32'h5C);
    clear_in();
    step();
    chk("lit_bypass_empty", 32'(v_o[2]), 32'h0);

    // overflow on lane1
    for (int i = 0; i < 6; i++) begin
      vp[1] = 1'b1; dp[1] = 8'hE0 + DW'(i);
      vrp[1] = 1'b1; drp[1] = DW'(i + 1);
      step();
    end
    chk("lit_ovf1", 32'(ovf_o[1]), 32'h1);
    clear_in();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lit_drain", 32'(d_o[1]), 32'(i + 1));
    end
    step();
    chk("lit_drain_done", 32'(v_o[1]), 32'h0);

    // idle FSM with a single pulse
    for (int i = 0; i < 6; i++) step();
    chk("lit_idle_before", 32'(idle_o), 32'h1);
    vp[3] = 1'b1; dp[3] = 8'h33;
    step();
    chk("lit_idle_fall", 32'(idle_o), 32'h0);
    clear_in();
    for (int i = 0; i < 3; i++) step();
    chk("lit_idle_hold", 32'(idle_o), 32'h0);
    step();
    chk("lit_idle_rise", 32'(idle_o), 32'h1);

    // idle held off while a buffer drains
    for (int i = 0; i < 3; i++) begin
      vp[0] = 1'b1; dp[0] = DW'(8'h70 + i);
      vrp[0] = 1'b1; drp[0] = DW'(8'h80 + i);
      step();
    end
    clear_in();
    for (int i = 0; i < 9; i++) step();
    chk("lit_idle_after_drain", 32'(idle_o), 32'h1);

    // pointer wrap on lane0
    for (int k = 0; k < 10; k++) begin
      vp[0] = (k == 0); dp[0] = 8'hF0;
      vrp[0] = 1'b1; drp[0] = DW'(k + 1);
      step();
      if (k >= 1) chk("lit_wrap_order", 32'(d_o[0]), 32'(k));
    end

    // asynchronous reset mid-stream
    #3 rst_n = 1'b0;
    #1;
    chk("lit_async_valid", 32'(v_o), 32'h0);
    chk("lit_async_data0", 32'(d_o[0]), 32'h0);
    chk("lit_async_idle", 32'(idle_o), 32'h1);
    model_reset();
    clear_in();
    step();
    rst_n = 1'b1;
    step();

    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      case ((i / 300) % 3)
        0: rand_in(40, 50);
        1: rand_in(70, 80);
        default: rand_in(10, 30);
      endcase
      if ($urandom_range(0, 99) < 8) clear_in();
      rst_n = ($urandom_range(0, 399) != 0);
      step();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

`default_nettype wire
